// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared instruction-cache geometry defaults and FSM state encoding
package icache_pkg;

  localparam int ICACHE_IDX_WIDTH_DEF = 6;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_REQ  = 2'd1,
    IC_WAIT = 2'd2,
    IC_DONE = 2'd3
  } ic_state_e;

endpackage

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache between fetcher and memory controller
module icache
  import icache_pkg::*;
#(
  parameter int ICACHE_IDX_WIDTH = ICACHE_IDX_WIDTH_DEF,
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            fet_icache_enable,
  input  logic [XLEN-1:0] fet_pc,
  output logic            icache_inst_ready,
  output logic [XLEN-1:0] icache_inst,
  output logic [XLEN-1:0] icache_inst_addr,
  output logic            icache_mem_enable,
  output logic [XLEN-1:0] icache_mem_pc,
  input  logic            mem_fet_busy,
  input  logic            mem_inst_ready,
  input  logic [XLEN-1:0] mem_inst_addr,
  input  logic [XLEN-1:0] mem_inst
);

  localparam int ENTRIES = 1 << ICACHE_IDX_WIDTH;
  localparam int TAG_W = XLEN - ICACHE_IDX_WIDTH - 1;

  ic_state_e state_q, state_d;
  logic [XLEN-1:0] miss_pc_q, miss_pc_d;
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0] data_q [ENTRIES];

  logic inst_ready_d, mem_enable_d, fill;
  logic [XLEN-1:0] inst_d, inst_addr_d, mem_pc_d;

  logic [ICACHE_IDX_WIDTH-1:0] fet_idx, miss_idx;
  logic hit;

  assign fet_idx = fet_pc[ICACHE_IDX_WIDTH:1];
  assign miss_idx = miss_pc_q[ICACHE_IDX_WIDTH:1];
  assign hit = valid_q[fet_idx] && (tag_q[fet_idx] == fet_pc[XLEN-1:ICACHE_IDX_WIDTH+1]);

  always_comb begin
    state_d = state_q;
    miss_pc_d = miss_pc_q;
    inst_ready_d = 1'b0;
    inst_d = icache_inst;
    inst_addr_d = icache_inst_addr;
    mem_enable_d = 1'b0;
    mem_pc_d = icache_mem_pc;
    fill = 1'b0;
    if (flush) begin
      state_d = IC_IDLE;
    end else begin
      case (state_q)
        IC_IDLE: begin
          // While the ready pulse is visible the fetcher still holds its old request.
          if (fet_icache_enable && !icache_inst_ready) begin
            if (hit) begin
              inst_d = data_q[fet_idx];
              inst_addr_d = fet_pc;
              inst_ready_d = 1'b1;
            end else begin
              miss_pc_d = fet_pc;
              state_d = IC_REQ;
            end
          end
        end
        IC_REQ: begin
          if (!mem_fet_busy) begin
            mem_enable_d = 1'b1;
            mem_pc_d = miss_pc_q;
            state_d = IC_WAIT;
          end
        end
        IC_WAIT: begin
          if (mem_inst_ready && (mem_inst_addr == miss_pc_q)) begin
            fill = 1'b1;
            inst_d = mem_inst;
            inst_addr_d = miss_pc_q;
            inst_ready_d = 1'b1;
            state_d = IC_DONE;
          end
        end
        default: state_d = IC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IC_IDLE;
      miss_pc_q <= '0;
      valid_q <= '0;
      icache_inst_ready <= 1'b0;
      icache_inst <= '0;
      icache_inst_addr <= '0;
      icache_mem_enable <= 1'b0;
      icache_mem_pc <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      miss_pc_q <= miss_pc_d;
      icache_inst_ready <= inst_ready_d;
      icache_inst <= inst_d;
      icache_inst_addr <= inst_addr_d;
      icache_mem_enable <= mem_enable_d;
      icache_mem_pc <= mem_pc_d;
      if (fill) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid_q gates every use.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_q[miss_idx] <= miss_pc_q[XLEN-1:ICACHE_IDX_WIDTH+1];
      data_q[miss_idx] <= mem_inst;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a line-level model
module tb_icache;

  logic        clk = 1'b0;
  logic        rst, rdy, flush, fet_icache_enable, mem_fet_busy, mem_inst_ready;
  logic [31:0] fet_pc, mem_inst_addr, mem_inst;
  logic        icache_inst_ready, icache_mem_enable;
  logic [31:0] icache_inst, icache_inst_addr, icache_mem_pc;

  int checks = 0;
  int failures = 0;

  // Model: each line remembers the full pc it was filled from.
  logic        line_valid [64];
  logic [31:0] line_pc [64];
  logic [31:0] mem_img [logic [31:0]];

  always #5 clk = ~clk;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .fet_icache_enable(fet_icache_enable), .fet_pc(fet_pc),
    .icache_inst_ready(icache_inst_ready), .icache_inst(icache_inst),
    .icache_inst_addr(icache_inst_addr), .icache_mem_enable(icache_mem_enable),
    .icache_mem_pc(icache_mem_pc), .mem_fet_busy(mem_fet_busy),
    .mem_inst_ready(mem_inst_ready), .mem_inst_addr(mem_inst_addr), .mem_inst(mem_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_word(input logic [31:0] pc, output logic [31:0] w);
    logic [31:0] r;
    if (!mem_img.exists(pc)) begin
      r = $urandom();
      mem_img[pc] = pc[1] ? {16'h0, r[15:0]} : r;
    end
    w = mem_img[pc];
  endtask

  function automatic bit model_hit(input logic [31:0] pc);
    return line_valid[pc[6:1]] && (line_pc[pc[6:1]] == pc);
  endfunction

  task automatic fetch(input logic [31:0] pc, input int busy, input int lat);
    bit exp_hit;
    int en_cyc, rdy_cyc, en_cnt, en_exp;
    logic prev_en;
    logic [31:0] exp_inst;
    exp_hit = model_hit(pc);
    get_word(pc, exp_inst);
    en_cyc = -1; rdy_cyc = -1; en_cnt = 0; prev_en = 1'b0;
    en_exp = (busy + 1 > 2) ? busy + 1 : 2;
    fet_pc = pc;
    fet_icache_enable = 1'b1;
    mem_fet_busy = (busy > 0);
    for (int cyc = 1; cyc <= 60 && rdy_cyc < 0; cyc++) begin
      step();
      if (cyc >= busy) mem_fet_busy = 1'b0;
      if (prev_en && icache_mem_enable) chk("mem_en_back_to_back", 32'(icache_mem_enable), 32'd0);
      prev_en = icache_mem_enable;
      if (icache_mem_enable) begin
        en_cnt++;
        en_cyc = cyc;
        chk("mem_pc", icache_mem_pc, pc);
      end
      if (icache_inst_ready) rdy_cyc = cyc;
      mem_inst_ready = 1'b0;
      if (en_cyc > 0 && cyc >= en_cyc + lat) begin
        mem_inst_ready = 1'b1;
        mem_inst_addr = pc;
        mem_inst = exp_inst;
      end else if (en_cyc > 0 && $urandom_range(0, 2) == 0) begin
        mem_inst_ready = 1'b1;
        mem_inst_addr = pc ^ 32'h4;
        mem_inst = $urandom();
      end
    end
    fet_icache_enable = 1'b0;
    chk("mem_en_count", en_cnt, exp_hit ? 0 : 1);
    if (!exp_hit) chk("mem_en_cycle", en_cyc, en_exp);
    chk("ready_latency", rdy_cyc, exp_hit ? 1 : en_exp + lat + 1);
    chk("inst", icache_inst, exp_inst);
    chk("inst_addr", icache_inst_addr, pc);
    // Matching response deliberately persists through the next edge.
    step();
    chk("ready_single_pulse", 32'(icache_inst_ready), 32'd0);
    chk("mem_en_after", 32'(icache_mem_enable), 32'd0);
    mem_inst_ready = 1'b0;
    mem_fet_busy = 1'b0;
    if (!exp_hit) begin
      line_valid[pc[6:1]] = 1'b1;
      line_pc[pc[6:1]] = pc;
    end
  endtask

  task automatic flush_miss(input logic [31:0] pc, input int extra);
    bit en_seen;
    logic [31:0] w;
    get_word(pc, w);
    en_seen = 1'b0;
    fet_pc = pc;
    fet_icache_enable = 1'b1;
    for (int cyc = 1; cyc <= 20 && !en_seen; cyc++) begin
      step();
      if (icache_mem_enable) en_seen = 1'b1;
    end
    chk("flush_en_seen", 32'(en_seen), 32'd1);
    repeat (extra) step();
    flush = 1'b1;
    mem_inst_ready = 1'b1;
    mem_inst_addr = pc;
    mem_inst = w;
    step();
    flush = 1'b0;
    fet_icache_enable = 1'b0;
    chk("flush_no_ready", 32'(icache_inst_ready), 32'd0);
    chk("flush_no_mem_en", 32'(icache_mem_enable), 32'd0);
    repeat (2) begin
      step();
      chk("flush_stale_ready", 32'(icache_inst_ready), 32'd0);
    end
    mem_inst_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    for (int i = 0; i < 64; i++) begin
      line_valid[i] = 1'b0;
      line_pc[i] = '0;
    end
    mem_img[32'h0] = 32'h0000_0513;
    mem_img[32'h2] = 32'h0000_4501;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; fet_icache_enable = 1'b0; fet_pc = '0;
    mem_fet_busy = 1'b0; mem_inst_ready = 1'b0; mem_inst_addr = '0; mem_inst = '0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_inst_ready", 32'(icache_inst_ready), 32'd0);
    chk("rst_inst", icache_inst, 32'd0);
    chk("rst_inst_addr", icache_inst_addr, 32'd0);
    chk("rst_mem_enable", 32'(icache_mem_enable), 32'd0);
    chk("rst_mem_pc", icache_mem_pc, 32'd0);

    fetch(32'h0, 0, 2);
    fetch(32'h0, 0, 0);
    fetch(32'h80, 0, 1);
    fetch(32'h0, 0, 3);
    fetch(32'h2, 0, 0);
    fetch(32'h2, 0, 0);
    fetch(32'h40, 5, 1);
    flush_miss(32'h100, 1);
    fetch(32'h100, 0, 2);

    // rdy low: a pending miss must not advance.
    rdy = 1'b0;
    fet_pc = 32'h204;
    fet_icache_enable = 1'b1;
    repeat (3) begin
      step();
      chk("rdy_hold_ready", 32'(icache_inst_ready), 32'd0);
      chk("rdy_hold_mem_en", 32'(icache_mem_enable), 32'd0);
    end
    rdy = 1'b1;
    fetch(32'h204, 0, 1);

    for (int n = 0; n < 80; n++) begin
      pc = 32'(($urandom_range(0, 7) << 1) | ($urandom_range(0, 3) << 7));
      if (!model_hit(pc) && $urandom_range(0, 7) == 0)
        flush_miss(pc, $urandom_range(0, 2));
      else
        fetch(pc, $urandom_range(0, 3), $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the fetcher and the memory controller's instruction port. Fetch requests that hit return in one cycle. Misses issue a single instruction fetch to the memory controller, wait for the returned instruction (32-bit, or 16-bit compressed zero-extended), fill the entry and forward it. Flush cancels any outstanding miss but keeps cached contents, because instruction memory is read-only.

## Interface
Parameters:
- ICACHE_IDX_WIDTH, 6, log2 of entry count; entries are indexed by pc[ICACHE_IDX_WIDTH:1].
- XLEN, global `XLEN (32), address/instruction width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; when low, all state and outputs hold
- flush  in  1  branch-mispredict flush, same cycle as the memory controller's flush
- fet_icache_enable  in  1  fetcher request valid, held until served
- fet_pc  in  XLEN  request address, halfword aligned
- icache_inst_ready  out  1  one-cycle pulse: icache_inst/icache_inst_addr valid
- icache_inst  out  XLEN  instruction; compressed instructions in [15:0], upper bits zero
- icache_inst_addr  out  XLEN  pc of icache_inst
- icache_mem_enable  out  1  one-cycle miss request to the memory controller (fet_mem_enable)
- icache_mem_pc  out  XLEN  miss address (fet_pc of the memory controller)
- mem_fet_busy  in  1  memory controller internally busy
- mem_inst_ready  in  1  memory controller instruction valid (level, may persist)
- mem_inst_addr  in  XLEN  pc of mem_inst
- mem_inst  in  XLEN  returned instruction

## Operation
- Storage per entry:
  - valid bit
  - tag = pc[XLEN-1:ICACHE_IDX_WIDTH+1]
  - 32-bit data
- On rst:
  - all valid bits cleared; state IDLE.
  - icache_inst_ready=0, icache_inst=0, icache_inst_addr=0, icache_mem_enable=0, icache_mem_pc=0.
- IDLE: when fet_icache_enable is high, look up fet_pc.
  - Hit: register data and pc to the outputs, pulse icache_inst_ready; stay in IDLE.
  - Miss: latch miss_pc=fet_pc; go to REQ.
- REQ:
  - If !mem_fet_busy: set icache_mem_enable=1 and icache_mem_pc=miss_pc for exactly one cycle, then go to WAIT.
  - Otherwise hold in REQ with icache_mem_enable=0.
- WAIT: when mem_inst_ready and mem_inst_addr==miss_pc:
  - write entry (valid=1, tag, data=mem_inst);
  - present mem_inst/miss_pc on the outputs with icache_inst_ready pulsed;
  - go to DONE.
  - A mem_inst_ready with a different address is ignored.
- DONE: one cycle, always returns to IDLE; no lookup is accepted in this cycle. This guards against the persistent mem_inst_ready being re-consumed.
- The fetcher drops or changes its request after seeing icache_inst_ready. A new lookup is accepted the cycle after a hit pulse.
- flush (rdy=1, highest priority after rst):
  - state goes to IDLE; icache_inst_ready=0; icache_mem_enable=0.
  - Any pending miss is abandoned with no fill, even if mem_inst_ready coincides.
  - Valid bits are kept.
- The cache is never written by stores; self-modifying code is unsupported.

## Timing
- Hit latency: request sampled at edge N, icache_inst_ready high after edge N+1, for one cycle.
- Miss latency: 1 cycle (IDLE→REQ) + busy wait + 1 (enable pulse) + memory latency + 1 (output register). icache_inst_ready rises the cycle after the matching mem_inst_ready is sampled.
- icache_mem_enable is never high for two consecutive cycles and never high outside REQ→WAIT.
- Lookup is combinational on fet_pc within the cycle; all outputs are registered.

## Structure
- Shared package/header (global_params.v): ICACHE_IDX_WIDTH default and state encodings IC_IDLE, IC_REQ, IC_WAIT, IC_DONE.
- A single module. The data/tag/valid arrays live in an inline register array, with no submodule.

## Test plan
- Cold miss: rst, then request pc=0x0000_0000; memory returns 0x0000_0513 on mem_inst_ready.
  - Expect one icache_mem_enable pulse with icache_mem_pc=0.
  - Expect icache_inst_ready one cycle later with icache_inst=0x0000_0513 and icache_inst_addr=0.
- Hit after fill: re-request pc=0 → icache_inst_ready one cycle later with 0x0000_0513 and no icache_mem_enable.
- Conflict: fill pc=0x0, then request pc=0x80 (same index when ICACHE_IDX_WIDTH=6).
  - Expect a miss and a refill.
  - A subsequent pc=0x0 request misses again.
- Compressed instruction: miss at pc=0x2; memory returns 0x0000_4501 → icache_inst=0x0000_4501; a re-request hits.
- Busy memory: mem_fet_busy high for 5 cycles during REQ → no enable during those cycles; the enable pulses on the first cycle busy is low.
- Flush mid-miss: flush in WAIT, then mem_inst_ready for the old pc → no icache_inst_ready and entry not valid; the next request to that pc misses.
